// File: rtl/mem_burst_arbiter_pkg.sv
// mem_arb_pkg: default geometry and FSM state type shared by mem_burst_arbiter files
package mem_arb_pkg;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_BURST_LEN = 4;
  localparam int OFS_W = $clog2(DEF_BURST_LEN);
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/mem_burst_arbiter_if.sv
// mem_burst_arbiter_if: requester handshakes and memory ports; master = arbiter, slave = requesters + memory
interface mem_burst_arbiter_if import mem_arb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic wack0, wack1, rvalid0, rvalid1, done0, done1;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_rd_addr, mem_wr_addr;
  logic [DATA_W-1:0] mem_rd_data, mem_wr_data;
  logic mem_we;
  modport master (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd_data,
    output wack0, wack1, rvalid0, rvalid1, done0, done1, rdata,
    output mem_rd_addr, mem_we, mem_wr_addr, mem_wr_data
  );
  modport slave (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd_data,
    input  wack0, wack1, rvalid0, rvalid1, done0, done1, rdata,
    input  mem_rd_addr, mem_we, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/mem_burst_arbiter_rr.sv
// rr_arbiter2: two-way round-robin; on a tie the requester not granted last wins
module rr_arbiter2 import mem_arb_pkg::*; (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  always_comb gnt = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter: round-robin line-burst sequencer for two cache requesters onto a 1R1W memory
// Define MEM_ARB_CWF_EN to start read bursts at the requested word (critical word first).
module mem_burst_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input logic clk,
  input logic rst_n,
  mem_burst_arbiter_if.master bus
);
  localparam int OW = $clog2(BURST_LEN);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_XFER = XFER;
  localparam logic [1:0] S_DONE = DONE;
  logic [1:0] r_state;
  logic r_gnt, r_dir, r_last, r_rv;
  logic [ADDR_W-1:0] r_base, r_rd_addr;
  logic [OW-1:0] r_start, r_beat;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0] w_gnt;
  logic w_sel, w_we, w_xfer, w_rd, w_wr;
  logic [ADDR_W-1:0] w_req_addr, w_addr;
  logic [OW-1:0] w_start, w_ofs;
  rr_arbiter2 u_rr (.req({bus.req1, bus.req0}), .last(r_last), .gnt(w_gnt));
  assign w_sel = w_gnt[1];
  assign w_we = w_sel ? bus.we1 : bus.we0;
  assign w_req_addr = w_sel ? bus.addr1 : bus.addr0;
`ifdef MEM_ARB_CWF_EN
  assign w_start = w_we ? '0 : w_req_addr[OW-1:0];
`else
  assign w_start = '0;
`endif
  // offset arithmetic is OW bits wide, so the burst wraps inside its line
  assign w_ofs = r_start + r_beat;
  assign w_addr = r_base | ADDR_W'(w_ofs);
  assign w_xfer = r_state == S_XFER;
  assign w_rd = w_xfer & ~r_dir;
  assign w_wr = w_xfer & r_dir;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt <= 1'b0;
      r_dir <= 1'b0;
      r_last <= 1'b1;
      r_rv <= 1'b0;
      r_base <= '0;
      r_start <= '0;
      r_beat <= '0;
      r_rdata <= '0;
      r_rd_addr <= '0;
    end else begin
      if (r_state == S_IDLE && w_gnt != 2'b00) begin
        r_state <= S_XFER;
        r_gnt <= w_sel;
        r_dir <= w_we;
        r_base <= w_req_addr & ~ADDR_W'(BURST_LEN - 1);
        r_start <= w_start;
        r_beat <= '0;
      end else if (w_xfer) begin
        r_beat <= r_beat + 1'b1;
        r_state <= (r_beat == OW'(BURST_LEN - 1)) ? S_DONE : S_XFER;
      end else if (r_state == S_DONE) begin
        r_last <= r_gnt;
        r_state <= S_IDLE;
      end
      r_rv <= w_rd;
      if (w_rd) begin
        r_rdata <= bus.mem_rd_data;
        r_rd_addr <= w_addr;
      end
    end
  assign bus.wack0 = w_wr & ~r_gnt;
  assign bus.wack1 = w_wr & r_gnt;
  assign bus.rvalid0 = r_rv & ~r_gnt;
  assign bus.rvalid1 = r_rv & r_gnt;
  assign bus.done0 = (r_state == S_DONE) & ~r_gnt;
  assign bus.done1 = (r_state == S_DONE) & r_gnt;
  assign bus.rdata = r_rdata;
  assign bus.mem_rd_addr = w_rd ? w_addr : r_rd_addr;
  assign bus.mem_we = w_wr;
  assign bus.mem_wr_addr = w_wr ? w_addr : '0;
  assign bus.mem_wr_data = w_wr ? (r_gnt ? bus.wdata1 : bus.wdata0) : '0;
endmodule

// File: doc/mem_burst_arbiter.md
# mem_burst_arbiter

Two-requester burst controller for the 512x16 single-read/single-write backing memory behind the 2-way L1 cache. It arbitrates line refills and writebacks from two requesters, for example the I-side and D-side cache controllers, using round-robin priority. Each granted request is sequenced as a fixed-length burst of word accesses onto the memory's read-address, write-enable, write-address and write-data ports. The block sits between the cache controllers and the memory; the memory itself is unchanged.

## Interface
- ADDR_W, 9, memory word-address width
- DATA_W, 16, memory word width
- BURST_LEN, 4, words per cache line; power of two, at least 2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  burst request; hold high until the matching done
- we0 / we1  in  1  1 = writeback, 0 = refill; sampled at grant
- addr0 / addr1  in  ADDR_W  word address; sampled at grant
- wdata0 / wdata1  in  DATA_W  write word; requester advances it after each wack
- wack0 / wack1  out  1  write word consumed this cycle
- rvalid0 / rvalid1  out  1  rdata holds a valid refill word
- rdata  out  DATA_W  registered read word, shared by both requesters
- done0 / done1  out  1  one-cycle pulse at burst completion
- mem_rd_addr  out  ADDR_W  to the memory read address
- mem_rd_data  in  DATA_W  combinational memory read data
- mem_we  out  1  memory write enable
- mem_wr_addr  out  ADDR_W  memory write address
- mem_wr_data  out  DATA_W  memory write data

## Operation
- FSM states: IDLE, XFER, DONE.
- **IDLE:** if any req is high, grant one requester.
  - Only one req high: that requester wins.
  - Both high: the requester not granted last wins. rr_last resets to 1, so requester 0 wins the first tie.
  - At the grant edge: register gnt, dir=weX, base=addrX with the low log2(BURST_LEN) bits cleared, start offset, and beat=0. Go to XFER.
- **XFER, one word per cycle:** word address = base | ((start + beat) mod BURST_LEN). Wrap stays inside the line; the address never crosses the line or wraps past 511.
  - Read: mem_rd_addr = word address. rdata <= mem_rd_data at the edge. rvalidG is high the following cycle.
  - Write: mem_we=1, mem_wr_addr = word address, mem_wr_data = wdataG, and wackG=1, all combinational in the same cycle.
  - After beat BURST_LEN-1: go to DONE.
- **DONE:** doneG=1 for one cycle. For a read, rvalidG carries the last word in this same cycle. Update rr_last=gnt, then go to IDLE.
- Outputs for the non-granted requester stay 0 at all times.
- mem_we is 0 outside XFER. mem_rd_addr holds its last value.
- A req that stays high after done is re-arbitrated as a new burst.
- A req dropped mid-burst is ignored; the burst completes.
- Reset, asynchronous, at any time:
  - state=IDLE, beat=0, rr_last=1, rdata=0, mem_rd_addr=0, mem_wr_addr=0.
  - All wack, rvalid, done and mem_we outputs are 0.
  - An in-flight burst is abandoned. Words already written stay written.

## Timing
- Grant edge E0.
- XFER cycles follow E0..E(BURST_LEN-1).
- DONE is the cycle after edge E(BURST_LEN).
- IDLE follows, and the next grant is possible at the following edge.
- Burst occupancy: BURST_LEN+2 cycles from grant edge to next grant edge.
- Read latency: first rvalid one cycle after the first XFER cycle, then one word per cycle with no gaps.
- Writes commit at edges E1..E(BURST_LEN).

## Configuration
- MEM_ARB_CWF_EN (critical word first):
  - **Defined:** read bursts start at the requested word, start = addr[log2(BURST_LEN)-1:0], and wrap modulo BURST_LEN.
  - **Undefined:** start=0 for reads.
  - Writes always use start=0, in both cases.

## Structure
- Package mem_arb_pkg holds:
  - ADDR_W, DATA_W and BURST_LEN defaults;
  - OFS_W = log2(BURST_LEN);
  - the FSM state enum typedef (IDLE/XFER/DONE).
- Sub-module rr_arbiter2: inputs req[1:0] and last; output one-hot gnt. Purely combinational.
- The top level instantiates rr_arbiter2 and holds the FSM, beat counter, rdata register and port muxing.

## Test plan
- **Refill, word 0:** preload mem[32..35]=1,3,7,15; req0, we0=0, addr0=32. Expect:
  - rvalid0 for 4 consecutive cycles with rdata 1,3,7,15;
  - done0 with the 4th word;
  - rvalid1, wack1 and done1 held at 0.
- **Writeback:** req1, we1=1, addr1=4, wdata A1,A2,A3,A4 advanced on wack1. Expect:
  - mem[4..7]=A1..A4;
  - mem_we high exactly 4 cycles;
  - done1 one cycle after the last write.
- **Simultaneous requests after reset:** req0 and req1 high together. Expect:
  - requester 0 served first;
  - requester 1 granted at the next arbitration;
  - a third burst from both high again goes to 0.
- **Critical word first, addr0=34:**
  - With MEM_ARB_CWF_EN: read order 7,15,1,3.
  - Without it: read order 1,3,7,15.
- **Reset mid-burst:** assert rst_n=0 after 2 write beats. Expect:
  - all outputs 0 immediately;
  - 2 words written, the other 2 unchanged;
  - after release, a new req0 is granted normally.
- **Held request:** req0 held continuously across 3 bursts. Expect:
  - grants spaced BURST_LEN+2 cycles apart;
  - req1 raised mid-burst is served next.
